receive_que_arbiter: RTL and testbench

Parametrised round-robin arbiter that merges `RECEIVE_QUE_SLOTS` receive queue slots into one push stream toward the shared receive FIFO. It grants one slot at a time for a whole frame, terminated by a last-word flag in the data MSB. It honours downstream back-pressure and finds the next requesting slot in one cycle instead of scanning one slot per cycle. It also counts forwarded frames and can optionally abort a stalled grant.

---
 rtl/receive_que_arbiter_pkg.sv | 15 +
 rtl/receive_que_arbiter_if.sv | 34 +++
 rtl/receive_que_arbiter_picker.sv | 27 ++
 rtl/receive_que_arbiter.sv | 153 +++++++++++++++
 tb/tb_receive_que_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/receive_que_arbiter_pkg.sv
// Shared types and helpers for the receive queue arbiter.
package receive_que_arbiter_pkg;

  typedef enum logic {
    S_IDLE        = 1'b0,
    S_PASSTHROUGH = 1'b1
  } state_type;

  localparam int unsigned FRAME_COUNT_WIDTH = 16;

  function automatic int unsigned slot_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/receive_que_arbiter_if.sv
// Slot-side and push-side signals of the receive queue arbiter.
interface receive_que_arbiter_if #(
  parameter int unsigned RECEIVE_QUE_SLOTS = 4,
  parameter int unsigned DATA_WIDTH        = 9
);
  import receive_que_arbiter_pkg::*;

  localparam int unsigned SLOT_WIDTH = slot_width(RECEIVE_QUE_SLOTS);

  logic [RECEIVE_QUE_SLOTS-1:0]                 enable;
  logic [RECEIVE_QUE_SLOTS-1:0][DATA_WIDTH-1:0] data;
  logic [RECEIVE_QUE_SLOTS-1:0]                 data_enable;
  logic                                         push_ready;
  logic [RECEIVE_QUE_SLOTS-1:0]                 ready;
  logic [DATA_WIDTH-1:0]                        push_data;
  logic                                         push_data_valid;
  logic                                         grant_active;
  logic [SLOT_WIDTH-1:0]                        grant_slot;
  logic [FRAME_COUNT_WIDTH-1:0]                 frame_count;
  logic                                         timeout_pulse;

  modport master (
    output enable, data, data_enable, push_ready,
    input  ready, push_data, push_data_valid, grant_active, grant_slot,
           frame_count, timeout_pulse
  );

  modport slave (
    input  enable, data, data_enable, push_ready,
    output ready, push_data, push_data_valid, grant_active, grant_slot,
           frame_count, timeout_pulse
  );

endinterface

// File: rtl/receive_que_arbiter_picker.sv
// Single-cycle rotating priority encoder: first request at or after pointer.
module rr_slot_picker #(
  parameter int unsigned RECEIVE_QUE_SLOTS = 4,
  parameter int unsigned SLOT_WIDTH        = 2
) (
  input  logic [RECEIVE_QUE_SLOTS-1:0] request,
  input  logic [SLOT_WIDTH-1:0]        pointer,
  output logic                         hit,
  output logic [SLOT_WIDTH-1:0]        index
);

  always_comb begin : pick
    int unsigned k;
    k     = 0;
    hit   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < RECEIVE_QUE_SLOTS; i++) begin
      k = 32'(pointer) + i;
      if (k >= RECEIVE_QUE_SLOTS) k = k - RECEIVE_QUE_SLOTS;
      if (!hit && request[k[SLOT_WIDTH-1:0]]) begin
        hit   = 1'b1;
        index = k[SLOT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/receive_que_arbiter.sv
// Round-robin frame arbiter merging receive queue slots into one push stream.
// Optional stall timeout enabled by defining RECEIVE_QUE_ARBITER_TIMEOUT_EN.
module receive_que_arbiter #(
  parameter int unsigned RECEIVE_QUE_SLOTS = 4,
  parameter int unsigned DATA_WIDTH        = 9,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  receive_que_arbiter_if.slave  bus
);
  import receive_que_arbiter_pkg::*;

  localparam int unsigned SLOT_WIDTH = slot_width(RECEIVE_QUE_SLOTS);
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(RECEIVE_QUE_SLOTS - 1);

  state_type                    state_q, state_d;
  logic [SLOT_WIDTH-1:0]        grant_slot_q, grant_slot_d;
  logic [SLOT_WIDTH-1:0]        rr_pointer_q, rr_pointer_d;
  logic [DATA_WIDTH-1:0]        push_data_q, push_data_d;
  logic                         push_data_valid_q, push_data_valid_d;
  logic                         grant_active_q, grant_active_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [RECEIVE_QUE_SLOTS-1:0] ready;
  logic [DATA_WIDTH-1:0]        grant_word;
  logic [SLOT_WIDTH-1:0]        next_pointer;
  logic                         pick_hit;
  logic [SLOT_WIDTH-1:0]        pick_index;

`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
  localparam int unsigned STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [STALL_WIDTH-1:0] stall_q, stall_d;
  logic                   timeout_pulse_q, timeout_pulse_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  rr_slot_picker #(
    .RECEIVE_QUE_SLOTS (RECEIVE_QUE_SLOTS),
    .SLOT_WIDTH        (SLOT_WIDTH)
  ) u_picker (
    .request (bus.enable),
    .pointer (rr_pointer_q),
    .hit     (pick_hit),
    .index   (pick_index)
  );

  always_comb begin
    grant_word   = bus.data[grant_slot_q];
    next_pointer = (grant_slot_q == LAST_SLOT) ? '0 : grant_slot_q + 1'b1;
  end

  always_comb begin
    state_d           = state_q;
    grant_slot_d      = grant_slot_q;
    rr_pointer_d      = rr_pointer_q;
    push_data_d       = push_data_q;
    push_data_valid_d = 1'b0;
    frame_count_d     = frame_count_q;
    ready             = '0;
`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
    stall_d           = stall_q;
    timeout_pulse_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_hit) begin
          grant_slot_d = pick_index;
          state_d      = S_PASSTHROUGH;
`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
          stall_d      = '0;
`endif
        end
      end
      S_PASSTHROUGH: begin
        // Abort takes priority over a word offered in the same cycle.
        if (!bus.enable[grant_slot_q]) begin
          state_d      = S_IDLE;
          rr_pointer_d = next_pointer;
        end else if (bus.data_enable[grant_slot_q] && bus.push_ready) begin
          ready[grant_slot_q] = 1'b1;
          push_data_d         = grant_word;
          push_data_valid_d   = 1'b1;
`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
          stall_d             = '0;
`endif
          if (grant_word[DATA_WIDTH-1]) begin
            state_d      = S_IDLE;
            rr_pointer_d = next_pointer;
            if (frame_count_q != '1) frame_count_d = frame_count_q + 1'b1;
          end
        end else begin
`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
          if (stall_q == STALL_LIMIT) begin
            state_d         = S_IDLE;
            rr_pointer_d    = next_pointer;
            timeout_pulse_d = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    grant_active_d = (state_d == S_PASSTHROUGH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      grant_slot_q      <= '0;
      rr_pointer_q      <= '0;
      push_data_q       <= '0;
      push_data_valid_q <= 1'b0;
      grant_active_q    <= 1'b0;
      frame_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      grant_slot_q      <= grant_slot_d;
      rr_pointer_q      <= rr_pointer_d;
      push_data_q       <= push_data_d;
      push_data_valid_q <= push_data_valid_d;
      grant_active_q    <= grant_active_d;
      frame_count_q     <= frame_count_d;
    end
  end

`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q         <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      stall_q         <= stall_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end
  assign bus.timeout_pulse = timeout_pulse_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

  assign bus.ready           = ready;
  assign bus.push_data       = push_data_q;
  assign bus.push_data_valid = push_data_valid_q;
  assign bus.grant_active    = grant_active_q;
  assign bus.grant_slot      = grant_slot_q;
  assign bus.frame_count     = frame_count_q;

endmodule

// File: tb/tb_receive_que_arbiter.sv
// Directed table-driven bench for receive_que_arbiter (4 slots, 9-bit words).
module tb_receive_que_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 9;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  receive_que_arbiter_if #(.RECEIVE_QUE_SLOTS(N), .DATA_WIDTH(DW)) bus ();

  receive_que_arbiter #(
    .RECEIVE_QUE_SLOTS (N),
    .DATA_WIDTH        (DW),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic             rst;
    logic [3:0]       en;
    logic [3:0]       de;
    logic             pr;
    logic [3:0][8:0]  dat;
    logic [3:0]       ex_ready;
    logic             ex_valid;
    logic [8:0]       ex_data;
    logic             ex_active;
    logic [1:0]       ex_slot;
    logic [15:0]      ex_count;
    logic [1:0]       ex_ptr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] en, input logic [3:0] de,
                              input logic pr, input logic [3:0][8:0] dat, input logic [3:0] er,
                              input logic ev, input logic [8:0] ed, input logic ea,
                              input logic [1:0] es, input logic [15:0] ec, input logic [1:0] ep);
    vec_t v;
    v.rst = rst; v.en = en; v.de = de; v.pr = pr; v.dat = dat;
    v.ex_ready = er; v.ex_valid = ev; v.ex_data = ed; v.ex_active = ea;
    v.ex_slot = es; v.ex_count = ec; v.ex_ptr = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] de, input logic pr,
                       input logic [3:0][8:0] dat);
    bus.enable      = en;
    bus.data_enable = de;
    bus.push_ready  = pr;
    bus.data        = dat;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_active"}, 32'(bus.grant_active), 0);
    check({tag, "_valid"},  32'(bus.push_data_valid), 0);
    check({tag, "_data"},   32'(bus.push_data), 0);
    check({tag, "_slot"},   32'(bus.grant_slot), 0);
    check({tag, "_count"},  32'(bus.frame_count), 0);
    check({tag, "_pulse"},  32'(bus.timeout_pulse), 0);
    check({tag, "_ready"},  32'(bus.ready), 0);
    check({tag, "_ptr"},    32'(dut.rr_pointer_q), 0);
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    drive('0, '0, 1'b1, '0);
    #1;
    check_zero("reset");
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][8:0] fd;
    fd = {9'h103, 9'h0FF, 9'h102, 9'h101};
    drive('0, '0, 1'b1, '0);

    // Single 3-word frame on slot 2
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, {9'h0EE, 9'h000, 9'h0EE, 9'h0EE}, 4'b0000, 0, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, {9'h0EE, 9'h011, 9'h0EE, 9'h0EE}, 4'b0100, 0, 9'h000, 1, 2, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, {9'h0EE, 9'h022, 9'h0EE, 9'h0EE}, 4'b0100, 1, 9'h011, 1, 2, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, {9'h0EE, 9'h1AA, 9'h0EE, 9'h0EE}, 4'b0100, 1, 9'h022, 1, 2, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, '0,                               4'b0000, 1, 9'h1AA, 0, 2, 1, 3));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, '0,                               4'b0000, 0, 9'h1AA, 0, 2, 1, 3));
    // Fairness across slots 0, 1, 3 with 1-word frames
    tbl.push_back(mk(1, 4'b1011, 4'b1011, 1, fd, 4'b0000, 0, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0001, 0, 9'h000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0000, 1, 9'h101, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0010, 0, 9'h101, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0000, 1, 9'h102, 0, 1, 2, 2));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b1000, 0, 9'h102, 1, 3, 2, 2));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0000, 1, 9'h103, 0, 3, 3, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0001, 0, 9'h103, 1, 0, 3, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0000, 1, 9'h101, 0, 0, 4, 1));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0010, 0, 9'h101, 1, 1, 4, 1));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b0000, 1, 9'h102, 0, 1, 5, 2));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, fd, 4'b1000, 0, 9'h102, 1, 3, 5, 2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, '0, 4'b0000, 1, 9'h103, 0, 3, 6, 0));
    // Back-pressure: push_ready low for 5 cycles mid-frame on slot 1
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, {9'h0DD, 9'h0DD, 9'h000, 9'h0DD}, 4'b0000, 0, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, {9'h0DD, 9'h0DD, 9'h031, 9'h0DD}, 4'b0010, 0, 9'h000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, {9'h0DD, 9'h0DD, 9'h032, 9'h0DD}, 4'b0000, 1, 9'h031, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, {9'h0DD, 9'h0DD, 9'h032, 9'h0DD}, 4'b0000, 0, 9'h031, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, {9'h0DD, 9'h0DD, 9'h032, 9'h0DD}, 4'b0010, 0, 9'h031, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, {9'h0DD, 9'h0DD, 9'h133, 9'h0DD}, 4'b0010, 1, 9'h032, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, '0,                               4'b0000, 1, 9'h133, 0, 1, 1, 2));
    // Abort: slot 1 drops enable after 2 words while still offering data
    tbl.push_back(mk(1, 4'b1010, 4'b1010, 1, {9'h1C3, 9'h000, 9'h041, 9'h000}, 4'b0000, 0, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 1, {9'h1C3, 9'h000, 9'h041, 9'h000}, 4'b0010, 0, 9'h000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 1, {9'h1C3, 9'h000, 9'h042, 9'h000}, 4'b0010, 1, 9'h041, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1010, 1, {9'h1C3, 9'h000, 9'h043, 9'h000}, 4'b0000, 1, 9'h042, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, {9'h1C3, 9'h000, 9'h043, 9'h000}, 4'b0000, 0, 9'h042, 0, 1, 0, 2));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, {9'h1C3, 9'h000, 9'h043, 9'h000}, 4'b1000, 0, 9'h042, 1, 3, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, '0,                               4'b0000, 1, 9'h1C3, 0, 3, 1, 0));

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      check($sformatf("row%0d_valid", i),  32'(bus.push_data_valid), 32'(tbl[i].ex_valid));
      check($sformatf("row%0d_data", i),   32'(bus.push_data),       32'(tbl[i].ex_data));
      check($sformatf("row%0d_active", i), 32'(bus.grant_active),    32'(tbl[i].ex_active));
      check($sformatf("row%0d_slot", i),   32'(bus.grant_slot),      32'(tbl[i].ex_slot));
      check($sformatf("row%0d_count", i),  32'(bus.frame_count),     32'(tbl[i].ex_count));
      check($sformatf("row%0d_ptr", i),    32'(dut.rr_pointer_q),    32'(tbl[i].ex_ptr));
      drive(tbl[i].en, tbl[i].de, tbl[i].pr, tbl[i].dat);
      #1;
      check($sformatf("row%0d_ready", i),  32'(bus.ready),           32'(tbl[i].ex_ready));
      tick();
    end

    // Reset mid-frame: count is 1 here, slot 0 is partway through a frame
    drive(4'b0001, 4'b0000, 1'b1, {9'h0, 9'h0, 9'h0, 9'h011});
    tick();
    check("midrst_grant", 32'(bus.grant_active), 1);
    drive(4'b0001, 4'b0001, 1'b1, {9'h0, 9'h0, 9'h0, 9'h011});
    tick();
    check("midrst_pre_valid", 32'(bus.push_data_valid), 1);
    check("midrst_pre_count", 32'(bus.frame_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    drive('0, '0, 1'b1, '0);
    #1;
    reset_n = 1'b1;
    tick();

    // Saturation from a preloaded count of 16'hFFFE
    force dut.frame_count_q = 16'hFFFE;
    #1;
    release dut.frame_count_q;
    #1;
    check("sat_preload", 32'(bus.frame_count), 32'h0000_FFFE);
    drive(4'b0001, 4'b0001, 1'b1, {9'h0, 9'h0, 9'h0, 9'h1AB});
    tick();
    tick();
    check("sat_first", 32'(bus.frame_count), 32'h0000_FFFF);
    check("sat_first_data", 32'(bus.push_data), 32'h1AB);
    tick();
    tick();
    check("sat_second", 32'(bus.frame_count), 32'h0000_FFFF);
    check("sat_second_valid", 32'(bus.push_data_valid), 1);
    drive('0, '0, 1'b1, '0);
    tick();

    // Stall on slot 0 with no data offered
    do_reset();
    drive(4'b0001, 4'b0000, 1'b1, '0);
`ifdef RECEIVE_QUE_ARBITER_TIMEOUT_EN
    begin
      int  act_cycles;
      bit  seen;
      act_cycles = 0;
      seen       = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (bus.timeout_pulse) seen = 1'b1;
        else if (bus.grant_active) act_cycles++;
      end
      check("timeout_seen", 32'(seen), 1);
      check("timeout_stall_cycles", 32'(act_cycles), 8);
      check("timeout_active_low", 32'(bus.grant_active), 0);
      check("timeout_count", 32'(bus.frame_count), 0);
      check("timeout_ptr", 32'(dut.rr_pointer_q), 1);
      tick();
      check("timeout_pulse_width", 32'(bus.timeout_pulse), 0);
      check("timeout_regrant", 32'(bus.grant_active), 1);
    end
`else
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.grant_active && !bus.timeout_pulse) hold++;
      end
      check("stall_grant_persists", 32'(hold), 20);
    end
`endif
    drive('0, '0, 1'b1, '0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
